// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the cache-line memory port arbiter.
//   state_e     : arbiter FSM states (IDLE, BUSY_I, BUSY_D, DONE)
//   owner_e     : encoding of the current/last bus owner (I-cache or D-cache)
//   *_DEF       : default line geometry and address width
//   line_bytes  : bytes per cache line for a given word count
//   beat_width  : width of the beat counter for a given word count
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int LINE_WORDS_DEF = 4;
  localparam int ADDR_W_DEF     = 32;

  // Bytes covered by one cache line of 32-bit words.
  function automatic int line_bytes(input int words);
    return words * 4;
  endfunction

  // A single-word line still needs a 1-bit counter to keep the vector legal.
  function automatic int beat_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the I-cache refill port, the D-cache refill/writeback port, the grant
// indications and the word-wide main-memory port.
//   master : the arbiter's view (drives grants, strobes, done pulses and the
//            memory request side)
//   slave  : the environment's view (caches and memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);

  // I-cache refill path
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_rvalid;
  logic              i_done;

  // D-cache refill / writeback path
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_wready;
  logic [31:0]       d_rdata;
  logic              d_rvalid;
  logic              d_done;

  // Current owner
  logic              gnt_i;
  logic              gnt_d;

  // Main-memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_rdata, i_rvalid, i_done,
    output d_wready, d_rdata, d_rvalid, d_done,
    output gnt_i, gnt_d,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_rdata, i_rvalid, i_done,
    input  d_wready, d_rdata, d_rvalid, d_done,
    input  gnt_i, gnt_d,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational grant picker used by the arbiter while it is idle.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on a simultaneous request the requester not served last wins
//   undefined : fixed priority, the D-cache always wins
// Ports:
//   i_ireq    in  I-cache request
//   i_dreq    in  D-cache request
//   i_last_d  in  last owner was the D-cache (round-robin build only)
//   o_valid   out at least one request present
//   o_owner   out selected requester
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_ireq,
  input  logic   i_dreq,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic   i_last_d,
`endif
  output logic   o_valid,
  output owner_e o_owner
);

  // Select the winner; a lone requester always wins.
  always_comb begin
    o_valid = i_ireq | i_dreq;
    o_owner = OWN_I;
    if (i_ireq && i_dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_owner = i_last_d ? OWN_I : OWN_D;
`else
      o_owner = OWN_D;
`endif
    end else if (i_dreq) begin
      o_owner = OWN_D;
    end else begin
      o_owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Sequences cache-line bursts from the I-cache refill path and the D-cache
// refill/writeback path onto one word-wide main-memory port. One requester is
// granted at a time; the burst steps the word address, counts LINE_WORDS beats
// and finishes with a one-cycle done pulse to the owner.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on simultaneous
// requests; otherwise the D-cache has fixed priority).
// Ports:
//   clk  in  clock, all state changes on the rising edge
//   rst  in  asynchronous active-high reset
//   bus  mem_port_arbiter_if.master: cache ports, grants, memory port
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.master  bus
);

  localparam int                LINE_BYTES = line_bytes(LINE_WORDS);
  localparam int                BEAT_W     = beat_width(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'(LINE_BYTES - 1);

  state_e            r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_gnt_i;
  logic              r_gnt_d;
  logic              r_i_done;
  logic              r_d_done;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e            r_last_owner;
`endif

  logic              w_pick_valid;
  owner_e            w_pick_owner;
  logic [ADDR_W-1:0] w_req_addr;
  logic [ADDR_W-1:0] w_req_base;
  logic [BEAT_W-1:0] w_next_beat;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_last_beat;

  mem_arb_pick u_pick (
    .i_ireq   (bus.i_req),
    .i_dreq   (bus.d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_d (r_last_owner == OWN_D),
`endif
    .o_valid  (w_pick_valid),
    .o_owner  (w_pick_owner)
  );

  // Line base of the winning request and the address of the following beat.
  always_comb begin
    w_req_addr  = (w_pick_owner == OWN_D) ? bus.d_addr : bus.i_addr;
    w_req_base  = w_req_addr & ~OFF_MASK;
    w_next_beat = r_beat + BEAT_W'(1);
    w_last_beat = (r_beat == BEAT_W'(LINE_WORDS - 1));
    // The offset field is zero in the base, so the beat offset never carries.
    w_next_addr = r_base + ADDR_W'({w_next_beat, 2'b00});
  end

  // Arbiter FSM: grant, burst stepping, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_base     <= '0;
      r_mem_addr <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_gnt_i    <= 1'b0;
      r_gnt_d    <= 1'b0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_owner <= OWN_D;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_base     <= w_req_base;
            r_beat     <= '0;
            r_mem_addr <= w_req_base;
            r_mem_req  <= 1'b1;
            if (w_pick_owner == OWN_D) begin
              r_state  <= BUSY_D;
              r_gnt_d  <= 1'b1;
              r_gnt_i  <= 1'b0;
              r_mem_we <= bus.d_we;
            end else begin
              r_state  <= BUSY_I;
              r_gnt_i  <= 1'b1;
              r_gnt_d  <= 1'b0;
              r_mem_we <= 1'b0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= w_pick_owner;
`endif
          end else begin
            r_state <= IDLE;
          end
        end

        BUSY_I, BUSY_D: begin
          // A low mem_ready leaves address, direction and beat untouched.
          if (bus.mem_ready) begin
            if (w_last_beat) begin
              r_beat     <= '0;
              r_mem_addr <= r_base;
              r_mem_req  <= 1'b0;
              r_mem_we   <= 1'b0;
              r_i_done   <= r_gnt_i;
              r_d_done   <= r_gnt_d;
              r_state    <= DONE;
            end else begin
              r_beat     <= w_next_beat;
              r_mem_addr <= w_next_addr;
            end
          end else begin
            r_state <= r_state;
          end
        end

        DONE: begin
          // Requester drops its request on this edge, so IDLE sees it low.
          r_i_done   <= 1'b0;
          r_d_done   <= 1'b0;
          r_gnt_i    <= 1'b0;
          r_gnt_d    <= 1'b0;
          r_mem_addr <= '0;
          r_state    <= IDLE;
        end

        default: begin
          r_state    <= IDLE;
          r_beat     <= '0;
          r_mem_addr <= '0;
          r_mem_req  <= 1'b0;
          r_mem_we   <= 1'b0;
          r_gnt_i    <= 1'b0;
          r_gnt_d    <= 1'b0;
          r_i_done   <= 1'b0;
          r_d_done   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_i     = r_gnt_i;
  assign bus.gnt_d     = r_gnt_d;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.i_done    = r_i_done;
  assign bus.d_done    = r_d_done;

  assign bus.mem_wdata = bus.d_wdata;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  // Strobes are qualified by mem_req: the grant is still held in DONE while
  // memory may keep mem_ready high, and that must not look like a beat.
  assign bus.i_rvalid  = bus.mem_ready & r_mem_req & r_gnt_i;
  assign bus.d_rvalid  = bus.mem_ready & r_mem_req & r_gnt_d & ~r_mem_we;
  assign bus.d_wready  = bus.mem_ready & r_mem_req & r_gnt_d &  r_mem_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench: each issued transaction pushes its expected beats and done
// pulse; a monitor pops and compares whenever the arbiter shows a beat or done.
// Honours ARB_ROUND_ROBIN_EN in its ordering model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LW = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_port_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          own_d;
    logic [31:0] addr;
    bit          we;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  bit          done_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] salt = 32'h0;
  bit          model_last_d = 1'b1;
  logic [31:0] wbuf [LW];
  int          wptr;
  bit          tog;
  int          stall_cnt;
  int          beats_seen;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ salt;
  endfunction

  assign bus.mem_rdata = rd_word(bus.mem_addr);

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Expected beats of one line transfer, in address order.
  function automatic void push_line(input bit own_d, input logic [31:0] a, input bit we);
    logic [31:0] base;
    beat_t b;
    base = a & ~32'(LW * 4 - 1);
    for (int k = 0; k < LW; k++) begin
      b.own_d = own_d;
      b.addr  = base + 32'(4 * k);
      b.we    = we;
      b.data  = we ? wbuf[k] : rd_word(b.addr);
      exp_q.push_back(b);
    end
    done_q.push_back(own_d);
    model_last_d = own_d;
  endfunction

  function automatic logic next_ready(input int mode);
    case (mode)
      0: return 1'b1;
      1: begin tog = ~tog; return tog; end
      2: return ($urandom_range(0, 3) != 0);
      3: begin
        if (beats_seen == 2 && stall_cnt < 5) begin
          stall_cnt++;
          return 1'b0;
        end
        return 1'b1;
      end
      default: return 1'b1;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every beat and done pulse against the scoreboard.
  initial begin
    beat_t       e;
    bit          o;
    int          pend;
    bit          prev_stall;
    logic [31:0] prev_addr;
    bit          prev_we;
    prev_stall = 1'b0;
    prev_addr  = 32'h0;
    prev_we    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk(!(bus.gnt_i && bus.gnt_d), "gnt_mutex", {bus.gnt_i, bus.gnt_d}, 32'h0);
        if (prev_stall)
          chk(bus.mem_req && bus.mem_addr == prev_addr && bus.mem_we == prev_we,
              "stall_hold", bus.mem_addr, prev_addr);
        if (bus.mem_req && bus.mem_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_beat", bus.mem_addr, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk(bus.gnt_d == e.own_d && bus.gnt_i == !e.own_d, "beat_owner",
                {bus.gnt_i, bus.gnt_d}, {!e.own_d, e.own_d});
            chk(bus.mem_addr == e.addr, "beat_addr", bus.mem_addr, e.addr);
            chk(bus.mem_we == e.we, "beat_we", bus.mem_we, e.we);
            if (!e.own_d) begin
              chk({bus.i_rvalid, bus.d_rvalid, bus.d_wready} == 3'b100, "i_strobes",
                  {bus.i_rvalid, bus.d_rvalid, bus.d_wready}, 32'h4);
              chk(bus.i_rdata == e.data, "i_rdata", bus.i_rdata, e.data);
            end else if (e.we) begin
              chk({bus.i_rvalid, bus.d_rvalid, bus.d_wready} == 3'b001, "d_wstrobe",
                  {bus.i_rvalid, bus.d_rvalid, bus.d_wready}, 32'h1);
              chk(bus.mem_wdata == e.data, "mem_wdata", bus.mem_wdata, e.data);
            end else begin
              chk({bus.i_rvalid, bus.d_rvalid, bus.d_wready} == 3'b010, "d_rstrobe",
                  {bus.i_rvalid, bus.d_rvalid, bus.d_wready}, 32'h2);
              chk(bus.d_rdata == e.data, "d_rdata", bus.d_rdata, e.data);
            end
          end
        end else begin
          chk({bus.i_rvalid, bus.d_rvalid, bus.d_wready} == 3'b000, "idle_strobes",
              {bus.i_rvalid, bus.d_rvalid, bus.d_wready}, 32'h0);
        end
        if (bus.i_done || bus.d_done) begin
          if (done_q.size() == 0) begin
            chk(1'b0, "unexpected_done", {bus.i_done, bus.d_done}, 32'h0);
          end else begin
            o = done_q.pop_front();
            chk(bus.d_done == o && bus.i_done == !o, "done_owner",
                {bus.i_done, bus.d_done}, {!o, o});
            pend = 0;
            foreach (exp_q[k]) if (exp_q[k].own_d == o) pend++;
            chk(pend == 0, "done_early", pend, 32'h0);
            chk(!bus.mem_req, "done_mem_req", bus.mem_req, 32'h0);
          end
        end
        prev_stall = bus.mem_req && !bus.mem_ready;
        prev_addr  = bus.mem_addr;
        prev_we    = bus.mem_we;
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk({bus.gnt_i, bus.gnt_d, bus.mem_req, bus.mem_we, bus.i_rvalid, bus.d_rvalid,
         bus.d_wready, bus.i_done, bus.d_done} == 9'h0, name,
        {bus.gnt_i, bus.gnt_d, bus.mem_req, bus.mem_we, bus.i_rvalid, bus.d_rvalid,
         bus.d_wready, bus.i_done, bus.d_done}, 32'h0);
    chk(bus.mem_addr == 32'h0, {name, "_addr"}, bus.mem_addr, 32'h0);
  endtask

  // One scenario: issue the request(s), play requester and memory until done.
  task automatic run_txn(input bit do_i, input bit do_d, input bit dwe, input bit drop,
                         input logic [31:0] ia, input logic [31:0] da,
                         input int mode, input bit timing_chk);
    bit first_d, i_fin, d_fin, s_w, s_id, s_dd, s_gi, s_gd;
    int req_cyc, gnt_cyc, done_cyc;
    salt = $urandom;
    for (int k = 0; k < LW; k++) wbuf[k] = $urandom;
    if (do_i && do_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      first_d = !model_last_d;
`else
      first_d = 1'b1;
`endif
      if (first_d) begin
        push_line(1'b1, da, dwe);
        push_line(1'b0, ia, 1'b0);
      end else begin
        push_line(1'b0, ia, 1'b0);
        push_line(1'b1, da, dwe);
      end
    end else if (do_d) begin
      push_line(1'b1, da, dwe);
    end else begin
      push_line(1'b0, ia, 1'b0);
    end
    tog = 1'b0; stall_cnt = 0; beats_seen = 0; wptr = 0;
    @(posedge clk); #1;
    bus.i_req = do_i; bus.i_addr = ia;
    bus.d_req = do_d; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = wbuf[0];
    bus.mem_ready = next_ready(mode);
    req_cyc = cyc; gnt_cyc = -1; done_cyc = -1;
    i_fin = !do_i; d_fin = !do_d;
    for (int n = 0; n < 400 && !(i_fin && d_fin); n++) begin
      @(negedge clk);
      s_w = bus.d_wready; s_id = bus.i_done; s_dd = bus.d_done;
      s_gi = bus.gnt_i; s_gd = bus.gnt_d;
      if (bus.mem_req && bus.mem_ready) beats_seen++;
      if ((s_gi || s_gd) && gnt_cyc < 0) gnt_cyc = cyc;
      if (s_id || s_dd) done_cyc = cyc;
      @(posedge clk); #1;
      if (s_w && wptr < LW - 1) wptr++;
      bus.d_wdata = wbuf[wptr];
      if (s_id) begin bus.i_req = 1'b0; i_fin = 1'b1; end
      else if (s_gi && drop) bus.i_req = 1'b0;
      if (s_dd) begin bus.d_req = 1'b0; d_fin = 1'b1; end
      else if (s_gd && drop) bus.d_req = 1'b0;
      bus.mem_ready = next_ready(mode);
    end
    chk(i_fin && d_fin, "txn_timeout", {i_fin, d_fin}, 32'h3);
    if (timing_chk) begin
      chk(gnt_cyc - req_cyc == 1, "grant_latency", gnt_cyc - req_cyc, 32'd1);
      chk(done_cyc - req_cyc == LW + 1, "done_latency", done_cyc - req_cyc, LW + 1);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Reset in the middle of an I refill: immediate zero outputs, no done.
  task automatic reset_mid_burst();
    salt = $urandom;
    push_line(1'b0, 32'h0000_2008, 1'b0);
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_2008; bus.mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_burst");
    exp_q.delete();
    done_q.delete();
    model_last_d = 1'b1;
    bus.i_req = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit          ti, td, tw, tdrop;
    int          tmode, typ;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 0, 1'b1);
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_3040, 0, 1'b0);
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2010, 32'h0000_3050, 0, 1'b0);
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_1230, 1, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_5a18, 3, 1'b0);
    reset_mid_burst();
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2008, 32'h0, 0, 1'b1);
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 2, 1'b0);

    for (int r = 0; r < 40; r++) begin
      typ   = $urandom_range(0, 2);
      ti    = (typ != 1);
      td    = (typ != 0);
      tw    = $urandom_range(0, 1);
      tdrop = $urandom_range(0, 1);
      tmode = $urandom_range(0, 2);
      run_txn(ti, td, tw, tdrop, $urandom, $urandom, tmode, (typ != 2) && (tmode == 0));
    end

    repeat (3) @(posedge clk);
    chk(exp_q.size() == 0, "leftover_beats", exp_q.size(), 32'h0);
    chk(done_q.size() == 0, "leftover_done", done_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
